// File: rtl/io_pkg.sv
// Shared I/O map and control/status register helpers for memory-mapped board peripherals.
// Latency: none (constants and pure functions only).
// Backpressure: none; the CPU data bus has no stall path into I/O devices.
package io_pkg;

    // Output-side devices
    localparam logic [31:0] IO_HEX_ADDR   = 32'hF0000000;
    localparam logic [31:0] IO_LEDR_ADDR  = 32'hF0000004;

    // Input-side devices
    localparam logic [31:0] IO_KDATA_ADDR = 32'hF0000010;
    localparam logic [31:0] IO_SDATA_ADDR = 32'hF0000014;
    localparam logic [31:0] IO_KCTRL_ADDR = 32'hF0000110;
    localparam logic [31:0] IO_SCTRL_ADDR = 32'hF0000114;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;
    localparam int IE_BIT      = 8;

`ifdef IO_IRQ_EN
    localparam logic IRQ_IMPL = 1'b1;
`else
    localparam logic IRQ_IMPL = 1'b0;
`endif

    typedef struct packed {
        logic ready;
        logic overrun;
        logic ie;
    } ctrl_t;

    // Bus image of a control/status register; unused bits read as zero.
    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w              = '0;
        w[READY_BIT]   = c.ready;
        w[OVERRUN_BIT] = c.overrun;
        w[IE_BIT]      = c.ie;
        return w;
    endfunction

    // Next control state. A new value always leaves Ready set, even when the
    // CPU is reading the old value in the same cycle; that read does not count
    // as losing data, so Overrun only sets when no read coincides. A new value
    // also beats an Overrun-clearing write.
    function automatic ctrl_t ctrl_next(input ctrl_t c, input logic evt, input logic rd,
                                        input logic wr, input logic wr_ovr, input logic wr_ie);
        ctrl_t n;
        n = c;
        if (wr && !wr_ovr) n.overrun = 1'b0;
        if (evt && c.ready && !rd) n.overrun = 1'b1;
        if (evt) n.ready = 1'b1;
        else if (rd) n.ready = 1'b0;
        n.ie = IRQ_IMPL & (wr ? wr_ie : c.ie);
        return n;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// Debounces a synchronized multi-bit input: output follows input once it has held for DEBOUNCE_CYCLES.
// Latency: stable updates DEBOUNCE_CYCLES+1 edges after raw first shows a new value.
// Backpressure: none; 'changed' is a one-cycle strobe, high in the cycle before stable takes a new value.
module sw_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             changed
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] last;
    logic [CW-1:0]    cnt;
    logic             settle;

    // The counter runs while raw matches its previous sample, so this is the
    // final qualifying cycle.
    assign settle  = (raw == last) && (cnt == CNT_LAST);
    assign changed = settle && (raw != stable);

    // Stability counter (restarts on any input change, saturates) and debounced output
    always_ff @(posedge clk) begin
        if (reset) begin
            last   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            last <= raw;
            if (raw != last) cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (settle) stable <= raw;
        end
    end

endmodule

// File: rtl/key_sw_device.sv
// Memory-mapped KEY/SW input responder with ready/overrun status and optional interrupt (IO_IRQ_EN).
// Latency: KEY edge to KDATA in 3 edges; SW edge to SDATA in DEBOUNCE_CYCLES+3 edges; reads combinational.
// Backpressure: none; unread values are overwritten and flagged through Overrun.
module key_sw_device
    import io_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(IO_KDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(IO_KCTRL_ADDR),
    parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(IO_SDATA_ADDR),
    parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(IO_SCTRL_ADDR),
    parameter int               DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] abus,
    input  logic             re,
    input  logic             we,
    input  logic [DBITS-1:0] dbus_in,
    output logic [DBITS-1:0] dbus_out,
    output logic             sel,
    input  logic [3:0]       KEY,
`ifdef IO_IRQ_EN
    output logic             intr,
`endif
    input  logic [9:0]       SW
);

    logic [3:0] key_s1, key_s2, kdata;
    logic [9:0] sw_s1, sw_s2, sdata;
    logic       sw_changed, k_evt;
    logic       hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    ctrl_t      kctrl, sctrl;
    logic       unused_wdata;

    assign unused_wdata = ^{dbus_in[DBITS-1:IE_BIT+1], dbus_in[IE_BIT-1:OVERRUN_BIT+1],
                            dbus_in[OVERRUN_BIT-1:0]};

    // Two-flop synchronizers, reset to the idle board levels (keys released, switches low)
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    sw_debouncer #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debouncer (
        .clk     (clk),
        .reset   (reset),
        .raw     (sw_s2),
        .stable  (sdata),
        .changed (sw_changed)
    );

    assign hit_kdata = (abus == ADDR_KDATA);
    assign hit_kctrl = (abus == ADDR_KCTRL);
    assign hit_sdata = (abus == ADDR_SDATA);
    assign hit_sctrl = (abus == ADDR_SCTRL);
    assign sel       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    // Keys are active-low on the board; KDATA reports pressed keys as 1
    assign k_evt = (~key_s2 != kdata);

    // KEY data register and both control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            kdata <= '0;
            kctrl <= '0;
            sctrl <= '0;
        end else begin
            kdata <= ~key_s2;
            kctrl <= ctrl_next(kctrl, k_evt, re && hit_kdata, we && hit_kctrl,
                               dbus_in[OVERRUN_BIT], dbus_in[IE_BIT]);
            sctrl <= ctrl_next(sctrl, sw_changed, re && hit_sdata, we && hit_sctrl,
                               dbus_in[OVERRUN_BIT], dbus_in[IE_BIT]);
        end
    end

    // Read data mux; zero whenever the address is not ours
    always_comb begin
        dbus_out = '0;
        if (hit_kdata)      dbus_out = DBITS'(kdata);
        else if (hit_kctrl) dbus_out = DBITS'(ctrl_word(kctrl));
        else if (hit_sdata) dbus_out = DBITS'(sdata);
        else if (hit_sctrl) dbus_out = DBITS'(ctrl_word(sctrl));
    end

`ifdef IO_IRQ_EN
    // Registered interrupt request from either enabled, ready source
    always_ff @(posedge clk) begin
        if (reset) intr <= 1'b0;
        else       intr <= (kctrl.ready & kctrl.ie) | (sctrl.ready & sctrl.ie);
    end
`endif

endmodule

// File: tb/tb_key_sw_device.sv
module tb_key_sw_device;

    localparam int          DC    = 4;
    localparam logic [31:0] KDATA = 32'hF0000010;
    localparam logic [31:0] KCTRL = 32'hF0000110;
    localparam logic [31:0] SDATA = 32'hF0000014;
    localparam logic [31:0] SCTRL = 32'hF0000114;
`ifdef IO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] abus = '0, dbus_in = '0, dbus_out;
    logic        re = 1'b0, we = 1'b0, sel;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic        intr_obs;
`ifdef IO_IRQ_EN
    logic        intr;
    assign intr_obs = intr;
`else
    assign intr_obs = 1'b0;
`endif

    key_sw_device #(.DBITS(32), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .abus(abus), .re(re), .we(we),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .sel(sel), .KEY(KEY),
`ifdef IO_IRQ_EN
        .intr(intr),
`endif
        .SW(SW)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [3:0]  cur_key = 4'hF;
    logic [9:0]  cur_sw = '0;
    logic [31:0] last_dout;
    logic        last_sel, last_intr;

    // Reference model: inputs reach the data path two edges late; SW value
    // is adopted once the debouncer has seen it on DC+1 consecutive edges.
    logic [3:0] key_dly[2];
    logic [9:0] sw_dly[2];
    logic [9:0] m_raw_last;
    int         m_run;
    logic [3:0] m_kdata;
    logic [9:0] m_sdata;
    logic       m_rdy[2], m_ovr[2], m_ie[2], m_intr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ctrl_img(input int ch);
        return {23'd0, m_ie[ch], 5'd0, m_ovr[ch], 1'b0, m_rdy[ch]};
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == KDATA) return {28'd0, m_kdata};
        if (a == KCTRL) return ctrl_img(0);
        if (a == SDATA) return {22'd0, m_sdata};
        if (a == SCTRL) return ctrl_img(1);
        return 32'd0;
    endfunction

    task automatic model_edge(input logic rst, input logic [31:0] a, input logic r, input logic w,
                              input logic [31:0] d, input logic [3:0] key, input logic [9:0] sw);
        logic [3:0] nk;
        logic [9:0] ns, raw;
        logic       evt[2], rd[2], wr[2];
        if (rst) begin
            key_dly = '{4'hF, 4'hF};
            sw_dly = '{10'd0, 10'd0};
            m_raw_last = '0; m_run = 1;
            m_kdata = '0; m_sdata = '0; m_intr = 1'b0;
            for (int c = 0; c < 2; c++) begin m_rdy[c] = 0; m_ovr[c] = 0; m_ie[c] = 0; end
            return;
        end
        raw = sw_dly[1];
        m_run = (raw == m_raw_last) ? m_run + 1 : 1;
        m_raw_last = raw;
        ns = (m_run >= DC + 1) ? raw : m_sdata;
        nk = ~key_dly[1];
        key_dly[1] = key_dly[0]; key_dly[0] = key;
        sw_dly[1] = sw_dly[0];   sw_dly[0] = sw;
        evt[0] = (nk != m_kdata); evt[1] = (ns != m_sdata);
        rd[0] = r && a == KDATA;  rd[1] = r && a == SDATA;
        wr[0] = w && a == KCTRL;  wr[1] = w && a == SCTRL;
        m_intr = IRQ && ((m_rdy[0] && m_ie[0]) || (m_rdy[1] && m_ie[1]));
        for (int c = 0; c < 2; c++) begin
            if (wr[c] && !d[2]) m_ovr[c] = 1'b0;
            if (evt[c] && m_rdy[c] && !rd[c]) m_ovr[c] = 1'b1;
            if (evt[c]) m_rdy[c] = 1'b1;
            else if (rd[c]) m_rdy[c] = 1'b0;
            if (IRQ && wr[c]) m_ie[c] = d[8];
        end
        m_kdata = nk; m_sdata = ns;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, advance model at posedge
    task automatic cycle(input logic [31:0] a, input logic r, input logic w,
                         input logic [31:0] d, input logic rst);
        @(negedge clk);
        abus = a; re = r; we = w; dbus_in = d; KEY = cur_key; SW = cur_sw; reset = rst;
        #1;
        last_dout = dbus_out; last_sel = sel; last_intr = intr_obs;
        if (!rst) begin
            chk("model_dout", dbus_out, exp_read(a));
            chk("model_sel", {31'd0, sel},
                {31'd0, (a == KDATA || a == KCTRL || a == SDATA || a == SCTRL)});
            if (IRQ) chk("model_intr", {31'd0, intr_obs}, {31'd0, m_intr});
        end
        @(posedge clk);
        model_edge(rst, a, r, w, d, cur_key, cur_sw);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic expect_reg(input string nm, input logic [31:0] a, input logic [31:0] exp);
        cycle(a, 1'b0, 1'b0, 32'd0, 1'b0);
        chk(nm, last_dout, exp);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic        exp_sel;
        logic [31:0] exp_dout;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{"rst_kdata", KDATA, 1'b1, 32'd0};
        tbl[1] = '{"rst_kctrl", KCTRL, 1'b1, 32'd0};
        tbl[2] = '{"rst_sdata", SDATA, 1'b1, 32'd0};
        tbl[3] = '{"rst_sctrl", SCTRL, 1'b1, 32'd0};
        tbl[4] = '{"rst_addr0", 32'h0, 1'b0, 32'd0};
        tbl[5] = '{"rst_near",  32'hF0000018, 1'b0, 32'd0};

        // Reset state and address decode
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].a, 1'b0, 1'b0, 32'd0, 1'b0);
            chk({tbl[i].nm, "_sel"}, {31'd0, last_sel}, {31'd0, tbl[i].exp_sel});
            chk(tbl[i].nm, last_dout, tbl[i].exp_dout);
            chk({tbl[i].nm, "_intr"}, {31'd0, last_intr}, 32'd0);
        end

        // KEY press: visible after exactly three edges; read clears Ready
        cur_key = 4'hE;
        idle(2);
        expect_reg("key_2edges", KDATA, 32'd0);
        expect_reg("key_3edges", KDATA, 32'd1);
        expect_reg("kctrl_ready", KCTRL, 32'd1);
        expect_reg("kctrl_after_peek", KCTRL, 32'd1);
        cycle(KDATA, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("kdata_read", last_dout, 32'd1);
        expect_reg("kctrl_cleared", KCTRL, 32'd0);

        // Two KEY events without a read: Overrun, cleared only by writing bit2=0
        do_reset(2);
        cur_key = 4'hE; idle(4);
        cur_key = 4'hC; idle(4);
        expect_reg("kdata_two", KDATA, 32'd3);
        expect_reg("kctrl_ovr", KCTRL, 32'd5);
        cycle(KCTRL, 1'b0, 1'b1, 32'd4, 1'b0);
        expect_reg("kctrl_wr4", KCTRL, 32'd5);
        cycle(KCTRL, 1'b0, 1'b1, 32'd0, 1'b0);
        expect_reg("kctrl_wr0", KCTRL, 32'd1);

        // KEY event coinciding with a KDATA read: Ready stays, no Overrun
        cycle(KDATA, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_reg("kctrl_clr2", KCTRL, 32'd0);
        cur_key = 4'hF;
        idle(2);
        cycle(KDATA, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_reg("kctrl_evt_rd", KCTRL, 32'd1);
        expect_reg("kdata_release", KDATA, 32'd0);

        // SW bouncing never settles; then a steady value lands DC+3 edges later
        for (int i = 0; i < 4; i++) begin
            cur_sw = (i % 2 == 0) ? 10'h3FF : 10'h000;
            idle(2);
        end
        cur_sw = 10'h3FF;
        idle(6);
        expect_reg("sw_before", SDATA, 32'd0);
        expect_reg("sw_settled", SDATA, 32'h3FF);
        expect_reg("sctrl_ready", SCTRL, 32'd1);

`ifdef IO_IRQ_EN
        // Interrupt follows Ready&IE by one cycle in both directions
        cycle(SDATA, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle(SCTRL, 1'b0, 1'b1, 32'h100, 1'b0);
        cur_sw = 10'h000;
        idle(7);
        expect_reg("sctrl_ie_rdy", SCTRL, 32'h101);
        chk("intr_lag", {31'd0, last_intr}, 32'd0);
        expect_reg("sctrl_ie_rdy2", SCTRL, 32'h101);
        chk("intr_set", {31'd0, last_intr}, 32'd1);
        cycle(SDATA, 1'b1, 1'b0, 32'd0, 1'b0);
        expect_reg("sctrl_ie_only", SCTRL, 32'h100);
        chk("intr_hold", {31'd0, last_intr}, 32'd1);
        idle(1);
        chk("intr_clear", {31'd0, last_intr}, 32'd0);
`endif

        // Reset in the middle of a debounce restarts the count from scratch
        cur_sw = 10'h000;
        do_reset(2);
        idle(8);
        cur_sw = 10'h3FF;
        idle(4);
        do_reset(1);
        idle(6);
        expect_reg("mid_rst_before", SDATA, 32'd0);
        expect_reg("mid_rst_after", SDATA, 32'h3FF);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            int sel_i;
            sel_i = $urandom_range(0, 6);
            case (sel_i)
                0: a = KDATA;
                1: a = KCTRL;
                2: a = SDATA;
                3: a = SCTRL;
                4: a = 32'h0;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) cur_key = 4'($urandom);
            if ($urandom_range(0, 15) == 0) cur_sw = 10'($urandom);
            cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom,
                  ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
